// File: rtl/deadtime_generator_pkg.sv
// Shared definitions for the bridge-leg dead-time blocks: FSM state encoding
// and the default dead-time configuration reused by every leg.
package deadtime_generator_pkg;

  typedef enum logic [1:0] {
    ST_SAFE = 2'd0,
    ST_DT   = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } dt_state_e;

  localparam int DEADTIME_DEFAULT = 10;
  localparam int DT_W_DEFAULT     = 8;

endpackage

// File: rtl/deadtime_generator_array.sv
// N independent bridge legs, one per regularized command bit.
// With DEADTIME_PROG_EN all legs share one runtime i_deadtime.
module deadtime_generator_array
  import deadtime_generator_pkg::*;
#(
  parameter int N        = 3,
  parameter int DEADTIME = DEADTIME_DEFAULT,
  parameter int DT_W     = DT_W_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic [N-1:0]    i_signal,
`ifdef DEADTIME_PROG_EN
  input  logic [DT_W-1:0] i_deadtime,
`endif
  output logic [N-1:0]    o_high,
  output logic [N-1:0]    o_low,
  output logic [N-1:0]    o_busy
);

  for (genvar gi = 0; gi < N; gi++) begin : g_leg
    deadtime_generator #(
      .DEADTIME (DEADTIME),
      .DT_W     (DT_W)
    ) u_leg (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_signal   (i_signal[gi]),
`ifdef DEADTIME_PROG_EN
      .i_deadtime (i_deadtime),
`endif
      .o_high     (o_high[gi]),
      .o_low      (o_low[gi]),
      .o_busy     (o_busy[gi])
    );
  end

endmodule

// File: rtl/deadtime_generator_counter.sv
// Dead-time interval counter: load to 1 with a latched length, increment while
// active, saturate at all-ones, flag when the latched length is reached.
module deadtime_counter #(
  parameter int DT_W = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic            i_inc,
  input  logic [DT_W-1:0] i_len,
  output logic            o_done
);

  localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);
  localparam logic [DT_W-1:0] CNT_MAX = '1;

  logic [DT_W-1:0] count_reg;
  logic [DT_W-1:0] len_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_reg <= '0;
      len_reg   <= CNT_ONE;
    end else if (i_load) begin
      count_reg <= CNT_ONE;
      // A zero length would never terminate, so it is promoted to one cycle
      len_reg   <= (i_len == '0) ? CNT_ONE : i_len;
    end else if (i_inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + CNT_ONE;
    end
  end

  assign o_done = (count_reg == len_reg);

endmodule

// File: rtl/deadtime_generator.sv
// Complementary half-bridge gate driver with guaranteed dead time.
// Optional DEADTIME_PROG_EN adds the runtime i_deadtime input.
module deadtime_generator
  import deadtime_generator_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEFAULT,
  parameter int DT_W     = DT_W_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic            i_signal,
`ifdef DEADTIME_PROG_EN
  input  logic [DT_W-1:0] i_deadtime,
`endif
  output logic            o_high,
  output logic            o_low,
  output logic            o_busy
);

  dt_state_e       state_reg, state_next;
  logic            target_reg, target_next;
  logic            cnt_load;
  logic            cnt_done;
  logic [DT_W-1:0] dt_len;
  logic            high_reg, low_reg, busy_reg;

`ifdef DEADTIME_PROG_EN
  assign dt_len = i_deadtime;
`else
  assign dt_len = DT_W'(DEADTIME);
  if ((DEADTIME < 1) || (DEADTIME > (2**DT_W) - 1)) begin : g_bad_deadtime
    $error("deadtime_generator: DEADTIME outside 1..2**DT_W-1");
  end
`endif

  deadtime_counter #(.DT_W(DT_W)) u_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (cnt_load),
    .i_inc   (state_reg == ST_DT),
    .i_len   (dt_len),
    .o_done  (cnt_done)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg  <= ST_SAFE;
      target_reg <= 1'b0;
      high_reg   <= 1'b0;
      low_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      // Outputs decode the next state so they change on the same edge as the FSM
      high_reg   <= (state_next == ST_HIGH);
      low_reg    <= (state_next == ST_LOW);
      busy_reg   <= (state_next == ST_DT);
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    cnt_load    = 1'b0;
    if (!i_enable) begin
      state_next = ST_SAFE;
    end else begin
      case (state_reg)
        ST_SAFE: begin
          state_next  = ST_DT;
          target_next = i_signal;
          cnt_load    = 1'b1;
        end
        ST_DT: begin
          // A changed command restarts the whole interval toward the new side
          if (i_signal != target_reg) begin
            target_next = i_signal;
            cnt_load    = 1'b1;
          end else if (cnt_done) begin
            state_next = target_reg ? ST_HIGH : ST_LOW;
          end
        end
        ST_HIGH: begin
          if (!i_signal) begin
            state_next  = ST_DT;
            target_next = 1'b0;
            cnt_load    = 1'b1;
          end
        end
        ST_LOW: begin
          if (i_signal) begin
            state_next  = ST_DT;
            target_next = 1'b1;
            cnt_load    = 1'b1;
          end
        end
        default: state_next = ST_SAFE;
      endcase
    end
  end

  assign o_high = high_reg;
  assign o_low  = low_reg;
  assign o_busy = busy_reg;

endmodule
